// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 25000;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_F12    = 8'h07;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_scan_decode.sv
// Combinational PS/2 set-2 scancode to Apple-1 7-bit ASCII translation.
module ps2_scan_decode (
    input  logic [7:0] scancode,
    input  logic       shift,
    input  logic       ctrl,
    output logic [6:0] ascii,
    output logic       valid
);

    logic [6:0] base;
    logic       is_letter;

    always_comb begin
        base  = 7'h00;
        valid = 1'b1;
        case (scancode)
            8'h1C: base = 7'h41;
            8'h32: base = 7'h42;
            8'h21: base = 7'h43;
            8'h23: base = 7'h44;
            8'h24: base = 7'h45;
            8'h2B: base = 7'h46;
            8'h34: base = 7'h47;
            8'h33: base = 7'h48;
            8'h43: base = 7'h49;
            8'h3B: base = 7'h4A;
            8'h42: base = 7'h4B;
            8'h4B: base = 7'h4C;
            8'h3A: base = 7'h4D;
            8'h31: base = 7'h4E;
            8'h44: base = 7'h4F;
            8'h4D: base = 7'h50;
            8'h15: base = 7'h51;
            8'h2D: base = 7'h52;
            8'h1B: base = 7'h53;
            8'h2C: base = 7'h54;
            8'h3C: base = 7'h55;
            8'h2A: base = 7'h56;
            8'h1D: base = 7'h57;
            8'h22: base = 7'h58;
            8'h35: base = 7'h59;
            8'h1A: base = 7'h5A;
            8'h16: base = shift ? 7'h21 : 7'h31;
            8'h1E: base = shift ? 7'h40 : 7'h32;
            8'h26: base = shift ? 7'h23 : 7'h33;
            8'h25: base = shift ? 7'h24 : 7'h34;
            8'h2E: base = shift ? 7'h25 : 7'h35;
            8'h36: base = shift ? 7'h5E : 7'h36;
            8'h3D: base = shift ? 7'h26 : 7'h37;
            8'h3E: base = shift ? 7'h2A : 7'h38;
            8'h46: base = shift ? 7'h28 : 7'h39;
            8'h45: base = shift ? 7'h29 : 7'h30;
            8'h4E: base = shift ? 7'h5F : 7'h2D;
            8'h55: base = shift ? 7'h2B : 7'h3D;
            8'h4C: base = shift ? 7'h3A : 7'h3B;
            8'h52: base = shift ? 7'h22 : 7'h27;
            8'h41: base = shift ? 7'h3C : 7'h2C;
            8'h49: base = shift ? 7'h3E : 7'h2E;
            8'h4A: base = shift ? 7'h3F : 7'h2F;
            // Brackets and backslash have no shifted form in the Apple-1 set.
            8'h54: base = 7'h5B;
            8'h5D: base = 7'h5C;
            8'h5B: base = 7'h5D;
            8'h5A: base = 7'h0D;
            8'h66: base = 7'h5F;
            8'h76: base = 7'h1B;
            8'h29: base = 7'h20;
            default: valid = 1'b0;
        endcase
    end

    assign is_letter = (base >= 7'h41) && (base <= 7'h5A);
    assign ascii     = (ctrl && is_letter) ? (base & 7'h1F) : base;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with Apple-1 KBD/KBDCR register interface.
// Define PS2_PARITY_CHECK_EN to discard frames failing odd parity.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on a clock edge)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling the stop bit; frame accepted when it is 1
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    input  logic       address,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic       clr_screen
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic clk_s1, clk_s2, clk_prev;
    logic din_s1, din_s2;
    logic ps2_edge;

    rx_state_t      state;
    logic [7:0]     shift_reg;
    logic [2:0]     bit_cnt;
    logic [TW-1:0]  timer;
    logic [7:0]     rx_byte;
    logic           rx_valid;
    logic           parity_ok;

    logic       brk_pending, ext_pending, shift_flag, ctrl_flag;
    logic       ready;
    logic [6:0] kbd_data;
    logic [6:0] dec_ascii;
    logic       dec_valid;
    logic       is_prefix, new_char, rd_data;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            din_s1   <= 1'b1;
            din_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            din_s1   <= ps2_din;
            din_s2   <= din_s1;
        end
    end

    assign ps2_edge = clk_prev & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    assign parity_ok = odd_parity_ok(shift_reg, parity_bit);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (ps2_edge) begin
                timer <= TIMER_LOAD;
                case (state)
                    ST_IDLE: begin
                        if (!din_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {din_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= din_s2;
`endif
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state    <= ST_IDLE;
                        rx_byte  <= shift_reg;
                        rx_valid <= din_s2 & parity_ok;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                // A stalled keyboard must not leave a half frame that would
                // swallow the start bit of the next one.
                if (timer == '0) begin
                    state     <= ST_IDLE;
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

    ps2_scan_decode u_decode (
        .scancode (rx_byte),
        .shift    (shift_flag),
        .ctrl     (ctrl_flag),
        .ascii    (dec_ascii),
        .valid    (dec_valid)
    );

    assign is_prefix = (rx_byte == SC_BREAK) || (rx_byte == SC_EXT);
    assign new_char  = rx_valid && !is_prefix && !brk_pending && !ext_pending && dec_valid;
    assign rd_data   = enable & r_en & ~address;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            brk_pending <= 1'b0;
            ext_pending <= 1'b0;
            shift_flag  <= 1'b0;
            ctrl_flag   <= 1'b0;
            clr_screen  <= 1'b0;
            kbd_data    <= '0;
            ready       <= 1'b0;
        end else begin
            if (new_char) begin
                kbd_data <= dec_ascii;
                ready    <= 1'b1;
            end else if (rd_data) begin
                ready <= 1'b0;
            end

            if (rx_valid) begin
                if (rx_byte == SC_BREAK) begin
                    brk_pending <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else begin
                    brk_pending <= 1'b0;
                    ext_pending <= 1'b0;
                    if (!ext_pending) begin
                        if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT)
                            shift_flag <= !brk_pending;
                        else if (rx_byte == SC_CTRL)
                            ctrl_flag <= !brk_pending;
                        else if (rx_byte == SC_F12)
                            clr_screen <= !brk_pending;
                    end
                end
            end
        end
    end

    always_comb begin
        dout = {1'b1, kbd_data};
        if (address)
            dout = {ready, 7'b0};
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: scancode-level model plus directed frames.
module tb_ps2_keyboard;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_din = 1'b1;
    logic       address = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] dout;
    logic       clr_screen;

    ps2_keyboard dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .enable     (enable),
        .ps2_clk    (ps2_clk),
        .ps2_din    (ps2_din),
        .address    (address),
        .r_en       (r_en),
        .dout       (dout),
        .clr_screen (clr_screen)
    );

    always #20 clk25 = ~clk25;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always @(posedge clk25) cyc = cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    string LETTERS = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    string SYM    = "1234567890-=;',./[\\]";
    string SYM_SH = "!@#$%^&*()_+:\"<>?[\\]";
    logic [7:0] sym_sc [20] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h4C, 8'h52,
                                8'h41, 8'h49, 8'h4A, 8'h54, 8'h5D, 8'h5B};
    logic [7:0] spec_sc [4] = '{8'h5A, 8'h66, 8'h76, 8'h29};
    logic [6:0] spec_ch [4] = '{7'h0D, 7'h5F, 7'h1B, 7'h20};

    bit m_brk, m_ext, m_shift, m_ctrl;
    logic [6:0] exp_data;
    bit exp_ready, exp_clr;

    typedef struct {
        int         at;
        bit         has_char;
        logic [6:0] ch;
        bit         clr_set;
        bit         clr_val;
    } pend_t;
    pend_t pend[$];

    function automatic bit lookup(input logic [7:0] sc, output logic [6:0] ch);
        ch = '0;
        for (int i = 0; i < 26; i++)
            if (letter_sc[i] == sc) begin
                ch = 7'(LETTERS[i]);
                if (m_ctrl) ch = ch & 7'h1F;
                return 1'b1;
            end
        for (int i = 0; i < 20; i++)
            if (sym_sc[i] == sc) begin
                ch = m_shift ? 7'(SYM_SH[i]) : 7'(SYM[i]);
                return 1'b1;
            end
        for (int i = 0; i < 4; i++)
            if (spec_sc[i] == sc) begin
                ch = spec_ch[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_byte(input logic [7:0] b, input int at);
        pend_t p;
        p.at = at; p.has_char = 0; p.ch = '0; p.clr_set = 0; p.clr_val = 0;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!m_ext) begin
                if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
                else if (b == 8'h14) m_ctrl = !m_brk;
                else if (b == 8'h07) begin p.clr_set = 1; p.clr_val = !m_brk; end
                else if (!m_brk && lookup(b, p.ch)) p.has_char = 1;
            end
            m_brk = 0;
            m_ext = 0;
            if (p.has_char || p.clr_set) pend.push_back(p);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        pend_t p;
        bit latched;
        forever begin
            @(posedge clk25);
            #1;
            if (!rst_n) begin
                m_brk = 0; m_ext = 0; m_shift = 0; m_ctrl = 0;
                exp_data = '0; exp_ready = 0; exp_clr = 0;
                pend.delete();
            end else begin
                latched = 0;
                while (pend.size() > 0 && pend[0].at <= cyc) begin
                    p = pend.pop_front();
                    if (p.has_char) begin exp_data = p.ch; exp_ready = 1; latched = 1; end
                    if (p.clr_set) exp_clr = p.clr_val;
                end
                if (enable && r_en && !address && !latched) exp_ready = 0;
            end
            check("cycle dout", dout, address ? {exp_ready, 7'b0} : {1'b1, exp_data});
            check("cycle clr_screen", {7'b0, clr_screen}, {7'b0, exp_clr});
        end
    end

    initial begin
        repeat (95000) @(posedge clk25);
        $display("FAIL watchdog: got %0d cycles, expected completion earlier", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic ps2_half(input logic b);
        @(negedge clk25); ps2_din = b;
        repeat (10) @(negedge clk25);
        ps2_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_good = 1,
                              input bit stop_good = 1, input bit rd_at_latch = 0);
        logic [10:0] bits;
        int c;
        bit ok;
        bits = {stop_good, (par_good ? ~^b : ^b), b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_half(bits[i]);
            c = cyc;
            if (i == 10) begin
                ok = stop_good;
`ifdef PS2_PARITY_CHECK_EN
                ok = ok && par_good;
`endif
                if (ok) model_byte(b, c + 4);
                if (rd_at_latch) begin
                    repeat (3) @(negedge clk25);
                    address = 1'b0; enable = 1'b1; r_en = 1'b1;
                    @(negedge clk25);
                    enable = 1'b0; r_en = 1'b0;
                    repeat (16) @(negedge clk25);
                end else begin
                    repeat (20) @(negedge clk25);
                end
            end else begin
                repeat (20) @(negedge clk25);
            end
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk25);
        end
        ps2_din = 1'b1;
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            ps2_half((i == 0) ? 1'b0 : 1'(i % 2));
            repeat (20) @(negedge clk25);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk25);
        end
        ps2_din = 1'b1;
    endtask

    task automatic peek(input logic a, input logic [7:0] exp, input string name);
        @(negedge clk25);
        address = a;
        #1;
        check(name, dout, exp);
    endtask

    task automatic cpu_read(input logic a, input logic [7:0] exp, input string name);
        @(negedge clk25);
        address = a; enable = 1'b1; r_en = 1'b1;
        #1;
        check(name, dout, exp);
        @(negedge clk25);
        enable = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk25);
        peek(1'b1, 8'h00, "reset kbdcr");
        peek(1'b0, 8'h80, "reset kbd");
        check("reset clr_screen", {7'b0, clr_screen}, 8'h00);
        @(negedge clk25); rst_n = 1'b1;
        repeat (5) @(negedge clk25);

        // Plain letter, status read keeps ready, disabled strobe ignored.
        send_frame(8'h1C);
        peek(1'b0, 8'hC1, "A kbd");
        peek(1'b1, 8'h80, "A kbdcr");
        @(negedge clk25); address = 1'b0; r_en = 1'b1; enable = 1'b0;
        @(negedge clk25); r_en = 1'b0;
        peek(1'b1, 8'h80, "read without enable");
        cpu_read(1'b1, 8'h80, "kbdcr read");
        peek(1'b1, 8'h80, "kbdcr read keeps ready");
        cpu_read(1'b0, 8'hC1, "A read");
        peek(1'b1, 8'h00, "ready cleared");

        // Shift make, shifted digit, shift break, plain digit.
        send_frame(8'h12);
        send_frame(8'h16);
        send_frame(8'hF0);
        send_frame(8'h12);
        cpu_read(1'b0, 8'hA1, "shift 1");
        send_frame(8'h16);
        cpu_read(1'b0, 8'hB1, "plain 1");

        // Bad stop bit, then parity error, then a good frame.
        send_frame(8'h1C, 1, 0);
        peek(1'b1, 8'h00, "bad stop");
        send_frame(8'h32, 0, 1);
`ifdef PS2_PARITY_CHECK_EN
        peek(1'b1, 8'h00, "bad parity dropped");
`else
        peek(1'b1, 8'h80, "bad parity ignored");
        cpu_read(1'b0, 8'hC2, "bad parity char");
`endif
        send_frame(8'h21);
        cpu_read(1'b0, 8'hC3, "after bad frames");

        // Abandoned partial frame.
        send_partial(5);
        repeat (25010) @(negedge clk25);
        send_frame(8'h5A);
        cpu_read(1'b0, 8'h8D, "enter after timeout");

        // Read colliding with a new character.
        send_frame(8'h1C);
        send_frame(8'h32, 1, 1, 1);
        peek(1'b1, 8'h80, "collide ready");
        peek(1'b0, 8'hC2, "collide data");
        cpu_read(1'b0, 8'hC2, "collide read");
        peek(1'b1, 8'h00, "plain read clears");

        // Ctrl letter and ctrl release.
        send_frame(8'h14);
        send_frame(8'h21);
        cpu_read(1'b0, 8'h83, "ctrl C");
        send_frame(8'hF0);
        send_frame(8'h14);
        send_frame(8'h21);
        cpu_read(1'b0, 8'hC3, "C after ctrl break");

        // Extended make and break are swallowed.
        send_frame(8'hE0);
        send_frame(8'h1C);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h1C);
        peek(1'b1, 8'h00, "extended dropped");

        // F12 drives clr_screen without producing a character.
        send_frame(8'h07);
        check("f12 make clr", {7'b0, clr_screen}, 8'h01);
        peek(1'b1, 8'h00, "f12 make no char");
        send_frame(8'hF0);
        send_frame(8'h07);
        check("f12 break clr", {7'b0, clr_screen}, 8'h00);
        peek(1'b1, 8'h00, "f12 break no char");

        // Reset in the middle of a frame.
        send_frame(8'h1C);
        send_frame(8'h07);
        send_partial(5);
        @(negedge clk25); rst_n = 1'b0;
        repeat (2) @(negedge clk25);
        peek(1'b1, 8'h00, "midframe reset kbdcr");
        check("midframe reset clr", {7'b0, clr_screen}, 8'h00);
        @(negedge clk25); rst_n = 1'b1;
        repeat (5) @(negedge clk25);
        send_frame(8'h1C);
        cpu_read(1'b0, 8'hC1, "after reset");

        repeat (10) @(negedge clk25);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
